// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-to-memory arbiter: state encoding and
// the default block address/data widths used by both caches and the arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 12;
    localparam int ARB_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that did not own the bus last.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_winner
);

    always_comb begin
        o_winner = 1'b0;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = ~i_last_owner;
            default: o_winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory slave between ICache (m0) and DCache (m1); grants are
// registered in IDLE, then the owner is routed combinationally to the slave.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic              grant_owner,
    output logic              busy
);

    arb_state_t r_state, w_next_state;
    logic       r_owner, r_last_owner, r_addr_done;
    logic       w_winner, w_win_wr;
    logic [1:0] w_wr_req, w_rd_req;

    logic [ADDR_W-1:0] w_own_araddr, w_own_awaddr;
    logic [DATA_W-1:0] w_own_wdata;
    logic              w_own_arvalid, w_own_rready, w_own_awvalid, w_own_wvalid;
    logic              w_ar_hs, w_r_done, w_w_done, w_rd_abort, w_wr_abort;

    assign w_wr_req = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
    assign w_rd_req = {m1_arvalid, m0_arvalid};

    rr_arb2 u_rr_arb2 (
        .i_req        (w_wr_req | w_rd_req),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner)
    );

    assign w_win_wr      = w_winner ? w_wr_req[1] : w_wr_req[0];
    assign w_own_araddr  = r_owner ? m1_araddr  : m0_araddr;
    assign w_own_arvalid = r_owner ? m1_arvalid : m0_arvalid;
    assign w_own_rready  = r_owner ? m1_rready  : m0_rready;
    assign w_own_awaddr  = r_owner ? m1_awaddr  : m0_awaddr;
    assign w_own_awvalid = r_owner ? m1_awvalid : m0_awvalid;
    assign w_own_wdata   = r_owner ? m1_wdata   : m0_wdata;
    assign w_own_wvalid  = r_owner ? m1_wvalid  : m0_wvalid;

    assign w_ar_hs    = (r_state == ST_READ) & w_own_arvalid & ~r_addr_done & s_arready;
    assign w_r_done   = (r_state == ST_READ) & s_rvalid & w_own_rready;
    assign w_w_done   = (r_state == ST_WRITE) & w_own_awvalid & w_own_wvalid & s_awready & s_wready;
    // Once the slave has the address the read runs to completion regardless of arvalid.
    assign w_rd_abort = (r_state == ST_READ) & ~r_addr_done & ~w_own_arvalid & ~w_r_done;
    assign w_wr_abort = (r_state == ST_WRITE) & ~(w_own_awvalid & w_own_wvalid);

    assign grant_owner = r_owner;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_addr_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && (|(w_wr_req | w_rd_req)))
                r_owner <= w_winner;
            if (w_r_done || w_w_done)
                r_last_owner <= r_owner;
            if (r_state != ST_READ || w_r_done || w_rd_abort)
                r_addr_done <= 1'b0;
            else if (w_ar_hs)
                r_addr_done <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|(w_wr_req | w_rd_req))
                    w_next_state = w_win_wr ? ST_WRITE : ST_READ;
            end
            ST_READ: begin
                if (w_r_done || w_rd_abort)
                    w_next_state = ST_IDLE;
            end
            ST_WRITE: begin
                if (w_w_done || w_wr_abort)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wvalid   = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rvalid  = 1'b0;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        case (r_state)
            ST_READ: begin
                s_araddr  = w_own_araddr;
                s_arvalid = w_own_arvalid & ~r_addr_done;
                s_rready  = w_own_rready;
                if (r_owner) begin
                    m1_arready = s_arready & ~r_addr_done;
                    m1_rdata   = s_rdata;
                    m1_rvalid  = s_rvalid;
                end else begin
                    m0_arready = s_arready & ~r_addr_done;
                    m0_rdata   = s_rdata;
                    m0_rvalid  = s_rvalid;
                end
            end
            ST_WRITE: begin
                s_awaddr  = w_own_awaddr;
                s_awvalid = w_own_awvalid;
                s_wdata   = w_own_wdata;
                s_wvalid  = w_own_wvalid;
                if (r_owner) begin
                    m1_awready = s_awready;
                    m1_wready  = s_wready;
                end else begin
                    m0_awready = s_awready;
                    m0_wready  = s_wready;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs checked on the
// falling edge, one task per scenario.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 128;

    logic          clk, rst;
    logic [AW-1:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
    logic          m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic          m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_arready, m1_arready, m0_rvalid, m1_rvalid;
    logic          m0_awready, m1_awready, m0_wready, m1_wready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] s_araddr, s_awaddr;
    logic          s_arvalid, s_arready, s_rvalid, s_rready;
    logic          s_awvalid, s_awready, s_wvalid, s_wready;
    logic [DW-1:0] s_rdata, s_wdata;
    logic          grant_owner, busy;

    int tests_run;
    int tests_failed;

    logic [DW-1:0] patA5;
    logic [DW-1:0] pat3C;
    logic [DW-1:0] wdat;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .grant_owner(grant_owner), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m0_awaddr = '0; m0_awvalid = 0; m0_wdata = '0; m0_wvalid = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wvalid = 0;
        s_arready = 0; s_rdata = '0; s_rvalid = 0; s_awready = 0; s_wready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Outputs must be quiet while reset is held, even with live requests.
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        m0_arvalid = 1; m0_rready = 1;
        m1_awvalid = 1; m1_wvalid = 1;
        s_rvalid = 1; s_rdata = patA5; s_arready = 1; s_awready = 1; s_wready = 1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
        tests_run++; if (grant_owner !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_grant: got %0b expected 0", grant_owner); end
        tests_run++; if ({s_arvalid, s_awvalid, s_wvalid, s_rready} !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_svalid: got %b expected 0000", {s_arvalid, s_awvalid, s_wvalid, s_rready}); end
        tests_run++; if ({m0_arready, m0_rvalid, m1_awready, m1_wready} !== 4'b0) begin tests_failed++; $display("[TB] FAIL rst_mready: got %b expected 0000", {m0_arready, m0_rvalid, m1_awready, m1_wready}); end
        tests_run++; if (m0_rdata !== '0) begin tests_failed++; $display("[TB] FAIL rst_rdata: got %h expected 0", m0_rdata); end
        clear_inputs();
        rst = 1'b1;
        @(negedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_after_busy: got %0b expected 0", busy); end
    endtask

    // Both masters read together after reset: m0, one idle cycle, then m1
    // (m0 re-requests during the gap, so the second tie goes to m1), then m0.
    task automatic test_tie_round_robin();
        do_reset();
        m0_araddr = 12'h010; m0_arvalid = 1; m0_rready = 1;
        m1_araddr = 12'h020; m1_arvalid = 1; m1_rready = 1;
        s_arready = 1;
        #1;
        tests_run++; if (s_arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_no_comb_path: got %0b expected 0", s_arvalid); end
        @(negedge clk); #1;
        tests_run++; if (grant_owner !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie1_owner: got %0b expected 0", grant_owner); end
        tests_run++; if (s_araddr !== 12'h010) begin tests_failed++; $display("[TB] FAIL tie1_addr: got %h expected 010", s_araddr); end
        tests_run++; if (m1_arready !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie1_m1_arready: got %0b expected 0", m1_arready); end
        @(negedge clk);
        m0_arvalid = 0; s_rvalid = 1; s_rdata = patA5;
        #1;
        tests_run++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin tests_failed++; $display("[TB] FAIL tie1_rvalid: got %b expected 10", {m0_rvalid, m1_rvalid}); end
        @(negedge clk);
        s_rvalid = 0; m0_araddr = 12'h030; m0_arvalid = 1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_turnaround1: got %0b expected 0", busy); end
        @(negedge clk); #1;
        tests_run++; if (grant_owner !== 1'b1) begin tests_failed++; $display("[TB] FAIL tie2_owner: got %0b expected 1", grant_owner); end
        tests_run++; if (s_araddr !== 12'h020) begin tests_failed++; $display("[TB] FAIL tie2_addr: got %h expected 020", s_araddr); end
        @(negedge clk);
        m1_arvalid = 0; s_rvalid = 1; s_rdata = pat3C;
        #1;
        tests_run++; if ({m0_arready, m0_rvalid, m1_rvalid} !== 3'b001) begin tests_failed++; $display("[TB] FAIL tie2_isolation: got %b expected 001", {m0_arready, m0_rvalid, m1_rvalid}); end
        tests_run++; if (m0_rdata !== '0 || m1_rdata !== pat3C) begin tests_failed++; $display("[TB] FAIL tie2_rdata: got m0=%h m1=%h expected m0=0 m1=%h", m0_rdata, m1_rdata, pat3C); end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_turnaround2: got %0b expected 0", busy); end
        @(negedge clk); #1;
        tests_run++; if (grant_owner !== 1'b0 || s_araddr !== 12'h030) begin tests_failed++; $display("[TB] FAIL tie3_grant: got owner=%0b addr=%h expected owner=0 addr=030", grant_owner, s_araddr); end
        @(negedge clk);
        m0_arvalid = 0; s_rvalid = 1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    // Lone m0 read: arready at N+1, rvalid at N+3, back to IDLE at N+4.
    task automatic test_single_read();
        m0_araddr = 12'h040; m0_arvalid = 1; m0_rready = 1;
        #1;
        tests_run++; if (busy !== 1'b0 || s_arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_cycleN: got busy=%0b arvalid=%0b expected 0 0", busy, s_arvalid); end
        @(negedge clk);
        s_arready = 1;
        #1;
        tests_run++; if (s_arvalid !== 1'b1 || s_araddr !== 12'h040) begin tests_failed++; $display("[TB] FAIL rd_addr: got arvalid=%0b addr=%h expected 1 040", s_arvalid, s_araddr); end
        tests_run++; if (m0_arready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_arready: got %0b expected 1", m0_arready); end
        @(negedge clk);
        m0_arvalid = 0; s_arready = 0;
        #1;
        tests_run++; if (busy !== 1'b1 || s_arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_addr_done: got busy=%0b arvalid=%0b expected 1 0", busy, s_arvalid); end
        @(negedge clk);
        s_rvalid = 1; s_rdata = patA5;
        #1;
        tests_run++; if (m0_rvalid !== 1'b1 || m0_rdata !== patA5) begin tests_failed++; $display("[TB] FAIL rd_data: got rvalid=%0b data=%h expected 1 %h", m0_rvalid, m0_rdata, patA5); end
        tests_run++; if (s_rready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_rready: got %0b expected 1", s_rready); end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        tests_run++; if (busy !== 1'b0 || m0_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_idle: got busy=%0b rvalid=%0b expected 0 0", busy, m0_rvalid); end
        clear_inputs();
        @(negedge clk);
    endtask

    // m1 posts a write and a read together: write first, then read.
    task automatic test_write_priority();
        m1_awaddr = 12'h3C0; m1_awvalid = 1; m1_wvalid = 1; m1_wdata = wdat;
        m1_araddr = 12'h100; m1_arvalid = 1; m1_rready = 1;
        s_awready = 1; s_wready = 1; s_arready = 1;
        @(negedge clk); #1;
        tests_run++; if (s_awvalid !== 1'b1 || s_awaddr !== 12'h3C0) begin tests_failed++; $display("[TB] FAIL wr_addr: got awvalid=%0b addr=%h expected 1 3c0", s_awvalid, s_awaddr); end
        tests_run++; if (s_wdata !== wdat || s_wvalid !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_data: got wvalid=%0b data=%h expected 1 %h", s_wvalid, s_wdata, wdat); end
        tests_run++; if (s_arvalid !== 1'b0 || m1_awready !== 1'b1 || m0_awready !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_route: got arvalid=%0b m1_awready=%0b m0_awready=%0b expected 0 1 0", s_arvalid, m1_awready, m0_awready); end
        @(negedge clk);
        m1_awvalid = 0; m1_wvalid = 0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_done_idle: got %0b expected 0", busy); end
        @(negedge clk); #1;
        tests_run++; if (s_arvalid !== 1'b1 || s_araddr !== 12'h100 || s_awvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_then_rd: got arvalid=%0b addr=%h awvalid=%0b expected 1 100 0", s_arvalid, s_araddr, s_awvalid); end
        @(negedge clk);
        m1_arvalid = 0; s_rvalid = 1; s_rdata = pat3C;
        #1;
        tests_run++; if (m1_rvalid !== 1'b1 || m1_rdata !== pat3C) begin tests_failed++; $display("[TB] FAIL wr_then_rd_data: got rvalid=%0b data=%h expected 1 %h", m1_rvalid, m1_rdata, pat3C); end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    // m0 read never accepted; m0 drops arvalid, arbiter returns to IDLE and serves m1.
    task automatic test_abort();
        m0_araddr = 12'h050; m0_arvalid = 1; m0_rready = 1;
        @(negedge clk);
        m1_araddr = 12'h200; m1_arvalid = 1; m1_rready = 1;
        #1;
        tests_run++; if (s_arvalid !== 1'b1 || m0_arready !== 1'b0 || grant_owner !== 1'b0) begin tests_failed++; $display("[TB] FAIL ab_stall: got arvalid=%0b arready=%0b owner=%0b expected 1 0 0", s_arvalid, m0_arready, grant_owner); end
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (busy !== 1'b1 || m1_arready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ab_hold: got busy=%0b m1_arready=%0b expected 1 0", busy, m1_arready); end
        @(negedge clk);
        m0_arvalid = 0;
        #1;
        tests_run++; if (s_arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ab_drop: got %0b expected 0", s_arvalid); end
        @(negedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ab_idle: got %0b expected 0", busy); end
        @(negedge clk);
        s_arready = 1;
        #1;
        tests_run++; if (grant_owner !== 1'b1 || s_araddr !== 12'h200 || m1_arready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ab_next_m1: got owner=%0b addr=%h arready=%0b expected 1 200 1", grant_owner, s_araddr, m1_arready); end
        @(negedge clk);
        m1_arvalid = 0; s_rvalid = 1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    // Reset while m1 waits for read data: abandoned at once, m0 wins the next tie.
    task automatic test_reset_mid();
        m1_araddr = 12'h0F0; m1_arvalid = 1; m1_rready = 1; s_arready = 1;
        @(negedge clk);
        @(negedge clk);
        m1_arvalid = 0; s_arready = 0;
        #1;
        tests_run++; if (busy !== 1'b1 || grant_owner !== 1'b1) begin tests_failed++; $display("[TB] FAIL rm_pre: got busy=%0b owner=%0b expected 1 1", busy, grant_owner); end
        #1;
        rst = 1'b0; s_rvalid = 1; s_rdata = patA5;
        #1;
        tests_run++; if (busy !== 1'b0 || grant_owner !== 1'b0 || s_rready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rm_async: got busy=%0b owner=%0b rready=%0b expected 0 0 0", busy, grant_owner, s_rready); end
        tests_run++; if (m1_rvalid !== 1'b0 || m1_rdata !== '0 || m0_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rm_no_complete: got m1_rvalid=%0b m1_rdata=%h m0_rvalid=%0b expected 0 0 0", m1_rvalid, m1_rdata, m0_rvalid); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        m0_araddr = 12'h011; m0_arvalid = 1; m0_rready = 1;
        m1_araddr = 12'h022; m1_arvalid = 1; m1_rready = 1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rm_idle: got %0b expected 0", busy); end
        @(negedge clk); #1;
        tests_run++; if (grant_owner !== 1'b0 || s_araddr !== 12'h011) begin tests_failed++; $display("[TB] FAIL rm_tie: got owner=%0b addr=%h expected 0 011", grant_owner, s_araddr); end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        patA5 = {16{8'hA5}};
        pat3C = {16{8'h3C}};
        wdat  = {4{32'hDEAD_0001}};
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_tie_round_robin();
        test_single_read();
        test_write_priority();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 12, memory block address width; DATA_W, default 128, block data width.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports m0_araddr/m1_araddr, input, ADDR_W, read address per master (m0 = ICache, m1 = DCache).
REQ-005 SHALL have ports mN_arvalid in 1, mN_arready out 1, mN_rdata out DATA_W, mN_rvalid out 1, mN_rready in 1.
REQ-006 SHALL have ports mN_awaddr in ADDR_W, mN_awvalid in 1, mN_awready out 1, mN_wdata in DATA_W, mN_wvalid in 1, mN_wready out 1.
REQ-007 SHALL have slave-side ports s_araddr, s_arvalid, s_awaddr, s_awvalid, s_wdata, s_wvalid, s_rready as outputs, and s_arready, s_rdata, s_rvalid, s_awready, s_wready as inputs, widths as for masters.
REQ-008 SHALL have port grant_owner, output, 1, current owner (0 = m0, 1 = m1); busy, output, 1, high outside IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, READ, WRITE; owner and last_owner registers.
REQ-010 Requests: wr_req_N = mN_awvalid & mN_wvalid; rd_req_N = mN_arvalid.
REQ-011 In IDLE, if any request is present, SHALL register owner and enter WRITE (owner has wr_req) else READ on next edge; otherwise remain in IDLE.
REQ-012 Owner selection: single requester wins; both requesting -> master != last_owner wins (round robin).
REQ-013 Within a master, write SHALL take priority over read.
REQ-014 Grant latency: request first seen in IDLE at cycle N -> slave-side valid asserted at cycle N+1; no combinational path from master valid to slave valid in IDLE.
REQ-015 In READ/WRITE, slave-side outputs SHALL be routed combinationally from the owner only; non-owner ready/valid outputs SHALL be 0 and its mN_rdata 0.
REQ-016 READ: addr_done flag SHALL set on s_arvalid & s_arready; s_arvalid SHALL be forced 0 once addr_done is set.
REQ-017 READ completes on s_rvalid & s_rready; WRITE completes on s_awready & s_wready (both in same cycle); on completion -> IDLE, last_owner <= owner, addr_done <= 0.
REQ-018 If owner drops its valid(s) before address acceptance, SHALL return to IDLE without updating last_owner.
REQ-019 After address acceptance the transaction SHALL NOT be aborted by master valid changes.
REQ-020 Minimum one IDLE cycle SHALL separate consecutive grants (turnaround).
REQ-021 s_rready SHALL equal owner's mN_rready in READ, 0 otherwise.
REQ-022 Simultaneous completion and new request: new request SHALL be evaluated only in the following IDLE cycle.

Reset
REQ-023 On rst low: state IDLE, owner 0, last_owner 1 (m0 wins first tie), addr_done 0.
REQ-024 All valid/ready outputs, busy, grant_owner SHALL be 0 during and immediately after reset; data outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it immediately; no completion reported to either master.

Structure
REQ-026 State encoding and ADDR_W/DATA_W defaults SHALL live in shared package mem_arb_pkg, used by both caches and arbiter.
REQ-027 Round-robin select logic SHALL be one sub-module rr_arb2 (2 requests, last_owner in, winner out); FSM and muxes in top.

Verification
REQ-028 Only m0 read 0x040, slave arready at N+1, rvalid with 0xA5..A5 at N+3 -> m0_rdata=0xA5..A5, m0_rvalid=1 one cycle, back to IDLE N+4.
REQ-029 m0 and m1 read simultaneously after reset -> m0 granted first, m1 granted after one IDLE cycle; second tie -> m1 first.
REQ-030 m1 asserts write 0x3C0 and read 0x100 together -> WRITE first, s_awaddr=0x3C0; then READ 0x100.
REQ-031 m0 read, slave never asserts arready, m0 drops arvalid at cycle 5 -> IDLE at 6, last_owner unchanged, m1 request served next.
REQ-032 rst asserted while READ awaits rvalid -> all outputs 0 asynchronously; after release, state IDLE, m0 wins first tie.
REQ-033 During m1 transaction, m0 arvalid held high -> m0_arready, m0_rvalid stay 0 until m1 completes.
